instruction_encoder: RTL and testbench
======================================

# instruction_encoder

Encodes one RISC-V RV64I instruction per transaction from decoded fields and a full-width signed immediate into a 32-bit instruction word. Writes the word sequentially into instruction memory, so it is the inverse of `immediate_decoder`. Used as the program loader in front of the instruction memory and as the stimulus generator for datapath benches. It range-checks the immediate against the selected format and refuses out-of-range or misaligned values.

## Interface
- `ADDR_WIDTH`, default 8: instruction-memory word-address width.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: field bundle valid.
- `in_ready` output 1: encoder can accept a bundle.
- `format` input 3: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6–7 illegal.
- `opcode` input 7: copied to bits [6:0].
- `funct3` input 3: R/I/S/B bits [14:12].
- `funct7` input 7: R bits [31:25].
- `rd`, `rs1`, `rs2` input 5 each: register fields.
- `imm` input 64, signed: full immediate value. For U, the value is the shifted upper immediate, e.g. 0x1000.
- `clear` input 1: synchronous; zeroes `mem_addr` and `err_count`, only while in IDLE.
- `mem_we` output 1: write request.
- `mem_ready` input 1: memory accepts the write this cycle.
- `mem_addr` output ADDR_WIDTH: word address of the current write.
- `mem_wdata` output 32: encoded instruction.
- `range_err` output 1: one-cycle pulse on a rejected bundle.
- `err_count` output 8: number of rejected bundles, saturating at 255.
- `wrapped` output 1: sticky; set when `mem_addr` wraps to 0.

## Operation
- FSM states: IDLE, CHECK, WRITE, ERR.
- IDLE: `in_ready`=1. On `in_valid`&`in_ready`, register all fields and go to CHECK.
- CHECK: compute the encoded word and the legality flag.
  - Legal: load `mem_wdata` and go to WRITE.
  - Illegal: go to ERR.
- WRITE: `mem_we`=1, with `mem_addr`/`mem_wdata` held stable. On `mem_ready`: `mem_addr` += 1 and go to IDLE.
- ERR: `range_err`=1 for one cycle; `err_count` += 1 (saturating); return to IDLE. `mem_addr` is unchanged.
- Legality rules:
  - I, S: −2048 ≤ imm ≤ 2047.
  - B: −4096 ≤ imm ≤ 4094 and imm[0]=0.
  - J: −2^20 ≤ imm ≤ 2^20−2 and imm[0]=0.
  - U: imm[11:0]=0 and imm[63:31] all equal (sign-extended 32-bit value).
  - R: imm is ignored, always legal.
  - format 6–7: illegal.
- Bit packing is standard RV:
  - I: imm[11:0] goes to [31:20].
  - S: imm[11:5] goes to [31:25], imm[4:0] to [11:7].
  - B: {imm[12], imm[10:5]} goes to [31:25], {imm[4:1], imm[11]} to [11:7].
  - U: imm[31:12] goes to [31:12].
  - J: {imm[20], imm[10:1], imm[11], imm[19:12]} goes to [31:12].
  - Register fields occupy only their format's slots; unused slots are zero.
- Address wrap: a write at 2^ADDR_WIDTH−1 moves `mem_addr` to 0 and sets `wrapped`. Only reset clears `wrapped`.
- `clear` outside IDLE is ignored. `clear` together with an accepted bundle: clear takes effect first, so the bundle is written at address 0.

## Timing
- Reset values: `in_ready`=0 during reset and 1 from the first clock after release. `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `range_err`=0, `err_count`=0, `wrapped`=0. FSM starts in IDLE.
- Latency: bundle accepted at edge N gives `mem_we`=1 after edge N+1; the earliest write completes at edge N+2. Peak throughput is one instruction per 3 cycles.
- Error path: `range_err` is high for the cycle after CHECK; `in_ready` is high again on the following cycle.
- Backpressure: WRITE holds indefinitely while `mem_ready`=0. `in_ready` stays 0 throughout.
- Reset asserted mid-WRITE: `mem_we` drops immediately (asynchronous), and the in-flight instruction is discarded.

## Structure
- Shared package `riscv_pkg`: format enum, opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR), and the immediate range limits.
- Sub-module `imm_packer`: combinational; inputs are format and immediate, outputs are the 32-bit immediate-bit mask contribution plus the legality flag. The same block serves as the golden model in the `immediate_decoder` round-trip bench.

## Test plan
- beq: format B, opcode 1100011, funct3 0, rs1=rs2=0, imm −20 → `mem_wdata`=0xFE0006E3 at address 0; `mem_addr` becomes 1.
- addi and sw back-to-back:
  - addi x5,x4,50 (I) → 0x03220293 at address 0.
  - sw x4,18(x0) (S, funct3 010) → 0x00402923 at address 1.
- auipc: auipc x5 (U, opcode 0010111), imm 0x1000 → 0x00001297.
- Rejected bundles: addi with imm 2048, then beq with imm 5 → two `range_err` pulses, `err_count`=2, no `mem_we`, `mem_addr` unchanged.
- Backpressure and wrap: `mem_ready` low for 3 cycles → `mem_we`/`mem_wdata` stable and `in_ready`=0. Preload 255 writes with ADDR_WIDTH=8 → next write lands at 255, `mem_addr`=0, `wrapped`=1.
- Reset mid-WRITE: assert `rst_n`=0 with `mem_we`=1 → all outputs return to reset values before the next edge; the first post-reset bundle is written at address 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV64I encoding definitions: instruction formats, major opcodes and
// the immediate ranges each format can represent.
package riscv_pkg;

    typedef enum logic [2:0] {
        FmtR = 3'd0,
        FmtI = 3'd1,
        FmtS = 3'd2,
        FmtB = 3'd3,
        FmtU = 3'd4,
        FmtJ = 3'd5
    } fmt_e;

    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;

    localparam longint ImmIMin = -64'sd2048;
    localparam longint ImmIMax = 64'sd2047;
    localparam longint ImmBMin = -64'sd4096;
    localparam longint ImmBMax = 64'sd4094;
    localparam longint ImmJMin = -64'sd1048576;
    localparam longint ImmJMax = 64'sd1048574;

endpackage

// File: rtl/imm_packer.sv
// Scatters a signed immediate into its format's instruction-bit slots and
// reports whether the format can represent the value exactly.
module imm_packer
    import riscv_pkg::*;
(
    input  logic [2:0]         fmt,
    input  logic signed [63:0] imm,
    output logic [31:0]        imm_bits,
    output logic               legal
);

    logic upper_sext;

    // U immediates must be a sign-extended 32-bit value.
    assign upper_sext = (&imm[63:31]) | ~(|imm[63:31]);

    always_comb begin
        imm_bits = '0;
        legal    = 1'b0;
        case (fmt)
            FmtR: begin
                legal = 1'b1;
            end
            FmtI: begin
                imm_bits = {imm[11:0], 20'b0};
                legal    = (imm >= ImmIMin) && (imm <= ImmIMax);
            end
            FmtS: begin
                imm_bits = {imm[11:5], 13'b0, imm[4:0], 7'b0};
                legal    = (imm >= ImmIMin) && (imm <= ImmIMax);
            end
            FmtB: begin
                imm_bits = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
                legal    = (imm >= ImmBMin) && (imm <= ImmBMax) && !imm[0];
            end
            FmtU: begin
                imm_bits = {imm[31:12], 12'b0};
                legal    = (imm[11:0] == 12'b0) && upper_sext;
            end
            FmtJ: begin
                imm_bits = {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
                legal    = (imm >= ImmJMin) && (imm <= ImmJMax) && !imm[0];
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instruction_encoder.sv
// Encodes one RV64I field bundle per transaction and writes the resulting word
// to sequential instruction-memory addresses, rejecting unrepresentable immediates.
module instruction_encoder
    import riscv_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            format,
    input  logic [6:0]            opcode,
    input  logic [2:0]            funct3,
    input  logic [6:0]            funct7,
    input  logic [4:0]            rd,
    input  logic [4:0]            rs1,
    input  logic [4:0]            rs2,
    input  logic signed [63:0]    imm,
    input  logic                  clear,
    output logic                  mem_we,
    input  logic                  mem_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  range_err,
    output logic [7:0]            err_count,
    output logic                  wrapped
);

    typedef enum logic [1:0] {StIdle, StCheck, StWrite, StErr} state_e;

    state_e             state_q;
    logic [2:0]         fmt_q;
    logic [6:0]         opcode_q;
    logic [2:0]         funct3_q;
    logic [6:0]         funct7_q;
    logic [4:0]         rd_q;
    logic [4:0]         rs1_q;
    logic [4:0]         rs2_q;
    logic signed [63:0] imm_q;

    logic [31:0] imm_bits;
    logic        imm_legal;
    logic [31:0] base_word;
    logic [31:0] enc_word;

    imm_packer u_imm_packer (
        .fmt      (fmt_q),
        .imm      (imm_q),
        .imm_bits (imm_bits),
        .legal    (imm_legal)
    );

    // Register fields only in the slots their format defines; others stay zero.
    always_comb begin
        base_word = {25'b0, opcode_q};
        case (fmt_q)
            FmtR:       base_word = {funct7_q, rs2_q, rs1_q, funct3_q, rd_q, opcode_q};
            FmtI:       base_word = {12'b0, rs1_q, funct3_q, rd_q, opcode_q};
            FmtS, FmtB: base_word = {7'b0, rs2_q, rs1_q, funct3_q, 5'b0, opcode_q};
            FmtU, FmtJ: base_word = {20'b0, rd_q, opcode_q};
            default:    base_word = {25'b0, opcode_q};
        endcase
    end

    assign enc_word = base_word | imm_bits;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            range_err <= 1'b0;
            err_count <= '0;
            wrapped   <= 1'b0;
            fmt_q     <= '0;
            opcode_q  <= '0;
            funct3_q  <= '0;
            funct7_q  <= '0;
            rd_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            imm_q     <= '0;
        end else begin
            range_err <= 1'b0;
            case (state_q)
                StIdle: begin
                    // A clear in the same cycle as an accept lands that bundle at 0.
                    if (clear) begin
                        mem_addr  <= '0;
                        err_count <= '0;
                    end
                    if (in_valid && in_ready) begin
                        fmt_q    <= format;
                        opcode_q <= opcode;
                        funct3_q <= funct3;
                        funct7_q <= funct7;
                        rd_q     <= rd;
                        rs1_q    <= rs1;
                        rs2_q    <= rs2;
                        imm_q    <= imm;
                        in_ready <= 1'b0;
                        state_q  <= StCheck;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                StCheck: begin
                    if (imm_legal) begin
                        mem_wdata <= enc_word;
                        mem_we    <= 1'b1;
                        state_q   <= StWrite;
                    end else begin
                        range_err <= 1'b1;
                        if (err_count != 8'hFF) begin
                            err_count <= err_count + 8'd1;
                        end
                        state_q <= StErr;
                    end
                end
                StWrite: begin
                    if (mem_ready) begin
                        mem_we   <= 1'b0;
                        mem_addr <= mem_addr + 1'b1;
                        if (&mem_addr) begin
                            wrapped <= 1'b1;
                        end
                        in_ready <= 1'b1;
                        state_q  <= StIdle;
                    end
                end
                StErr: begin
                    in_ready <= 1'b1;
                    state_q  <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_encoder.sv
// Randomised and directed bench for instruction_encoder against a
// transaction-level encoding model kept in the bench.
module tb_instruction_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  format = '0;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic [6:0]  funct7 = '0;
    logic [4:0]  rd = '0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic signed [63:0] imm = '0;
    logic        clear = 1'b0;
    logic        mem_we;
    logic        mem_ready = 1'b0;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        range_err;
    logic [7:0]  err_count;
    logic        wrapped;

    instruction_encoder #(.ADDR_WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .format    (format),
        .opcode    (opcode),
        .funct3    (funct3),
        .funct7    (funct7),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .imm       (imm),
        .clear     (clear),
        .mem_we    (mem_we),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .range_err (range_err),
        .err_count (err_count),
        .wrapped   (wrapped)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        logic [31:0] data;
        logic [7:0]  addr;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] wlog_data[$];
    logic [7:0]  wlog_addr[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          err_pulses = 0;
    int          m_addr = 0;
    int          m_err = 0;
    bit          m_wrapped = 1'b0;
    bit          rand_ready = 1'b0;
    bit          prev_err = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    function automatic longint fld(input longint v, input int hi, input int lo);
        return (v >> lo) & ((64'sd1 <<< (hi - lo + 1)) - 64'sd1);
    endfunction

    // Encoding reference from the ISA's field layout and value ranges.
    function automatic void model(input logic [2:0] f, input logic [6:0] opc,
                                  input logic [2:0] f3, input logic [6:0] f7,
                                  input logic [4:0] vrd, input logic [4:0] vrs1,
                                  input logic [4:0] vrs2, input longint v,
                                  output bit legal, output logic [31:0] w);
        longint x;
        longint r_d, r_s1, r_s2, fn3;
        r_d  = longint'(vrd) << 7;
        r_s1 = longint'(vrs1) << 15;
        r_s2 = longint'(vrs2) << 20;
        fn3  = longint'(f3) << 12;
        x = longint'(opc);
        legal = 1'b0;
        case (f)
            3'd0: begin
                legal = 1'b1;
                x += r_d + fn3 + r_s1 + r_s2 + (longint'(f7) << 25);
            end
            3'd1: begin
                legal = (v >= -2048) && (v <= 2047);
                x += r_d + fn3 + r_s1 + (fld(v, 11, 0) << 20);
            end
            3'd2: begin
                legal = (v >= -2048) && (v <= 2047);
                x += fn3 + r_s1 + r_s2 + (fld(v, 11, 5) << 25) + (fld(v, 4, 0) << 7);
            end
            3'd3: begin
                legal = (v >= -4096) && (v <= 4094) && ((v & 1) == 0);
                x += fn3 + r_s1 + r_s2 + (fld(v, 12, 12) << 31) + (fld(v, 10, 5) << 25)
                   + (fld(v, 4, 1) << 8) + (fld(v, 11, 11) << 7);
            end
            3'd4: begin
                legal = ((v & 64'hFFF) == 0) && (v >= -64'sd2147483648)
                     && (v < 64'sd2147483648);
                x += r_d + (fld(v, 31, 12) << 12);
            end
            3'd5: begin
                legal = (v >= -1048576) && (v <= 1048574) && ((v & 1) == 0);
                x += r_d + (fld(v, 20, 20) << 31) + (fld(v, 10, 1) << 21)
                   + (fld(v, 11, 11) << 20) + (fld(v, 19, 12) << 12);
            end
            default: legal = 1'b0;
        endcase
        w = x[31:0];
    endfunction

    // Random mem_ready backpressure when enabled.
    always begin
        @(posedge clk);
        #1;
        if (rand_ready) mem_ready = ($urandom_range(0, 3) != 0);
    end

    // Compare process: every write handshake and error pulse against the model queue.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_err = 1'b0;
        end else begin
            if (prev_err) begin
                check("err_pulse_width", {63'b0, range_err}, 64'd0);
                check("ready_after_err", {63'b0, in_ready}, 64'd1);
            end
            if (mem_we) check("busy_while_write", {63'b0, in_ready}, 64'd0);
            if (mem_we && mem_ready) begin
                if (exp_q.size() == 0 || exp_q[0].is_err) begin
                    check("unexpected_write", 64'd1, 64'd0);
                end else begin
                    check("write_addr", {56'b0, mem_addr}, {56'b0, exp_q[0].addr});
                    check("write_data", {32'b0, mem_wdata}, {32'b0, exp_q[0].data});
                    void'(exp_q.pop_front());
                end
                wlog_data.push_back(mem_wdata);
                wlog_addr.push_back(mem_addr);
            end
            if (range_err) begin
                err_pulses++;
                if (exp_q.size() == 0 || !exp_q[0].is_err) begin
                    check("unexpected_err", 64'd1, 64'd0);
                end else begin
                    check("err_count_at_err", {56'b0, err_count}, 64'(m_err_at_pop()));
                    void'(exp_q.pop_front());
                end
            end
            prev_err = range_err;
        end
    end

    // Expected count at the pulse equals model count minus errors still queued behind.
    function automatic int m_err_at_pop();
        int later = 0;
        for (int i = 1; i < exp_q.size(); i++) if (exp_q[i].is_err) later++;
        return (m_err - later);
    endfunction

    task automatic send(input logic [2:0] f, input logic [6:0] opc, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [4:0] vrd, input logic [4:0] vrs1,
                        input logic [4:0] vrs2, input longint v, input bit clr);
        bit          legal;
        logic [31:0] w;
        bit          ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check("send_ready_timeout", 64'd0, 64'd1);
            return;
        end
        format = f; opcode = opc; funct3 = f3; funct7 = f7;
        rd = vrd; rs1 = vrs1; rs2 = vrs2; imm = v; clear = clr; in_valid = 1'b1;
        if (clr) begin
            m_addr = 0;
            m_err = 0;
        end
        model(f, opc, f3, f7, vrd, vrs1, vrs2, v, legal, w);
        if (legal) begin
            exp_q.push_back('{1'b0, w, 8'(m_addr)});
            if (m_addr == 255) begin
                m_addr = 0;
                m_wrapped = 1'b1;
            end else begin
                m_addr++;
            end
        end else begin
            exp_q.push_back('{1'b1, 32'h0, 8'h0});
            if (m_err < 255) m_err++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clear = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (in_ready && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("idle_timeout", 64'd0, 64'd1);
    endtask

    task automatic check_state();
        wait_idle();
        check("mem_addr", {56'b0, mem_addr}, 64'(m_addr));
        check("err_count", {56'b0, err_count}, 64'(m_err));
        check("wrapped", {63'b0, wrapped}, {63'b0, m_wrapped});
    endtask

    task automatic wait_we();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_we) break;
        end
        check("mem_we_seen", {63'b0, mem_we}, 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, {63'b0, in_ready}, 64'd0);
        check({tag, "_mem_we"}, {63'b0, mem_we}, 64'd0);
        check({tag, "_mem_addr"}, {56'b0, mem_addr}, 64'd0);
        check({tag, "_mem_wdata"}, {32'b0, mem_wdata}, 64'd0);
        check({tag, "_range_err"}, {63'b0, range_err}, 64'd0);
        check({tag, "_err_count"}, {56'b0, err_count}, 64'd0);
        check({tag, "_wrapped"}, {63'b0, wrapped}, 64'd0);
    endtask

    initial begin
        longint bnd[16] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4095, 4096, -4098,
                            -1048576, 1048574, 1048576, -1048578, 64'sh7FFFF000,
                            -64'sh80000000, 64'sh80000000};
        longint      v;
        int          err0;
        logic [31:0] held;

        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        #1;
        check("in_ready_before_edge", {63'b0, in_ready}, 64'd0);
        @(posedge clk);
        #1;
        check("in_ready_after_edge", {63'b0, in_ready}, 64'd1);

        // beq x0,x0,-20 with latency checks
        mem_ready = 1'b1;
        send(3'd3, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, -20, 1'b0);
        @(negedge clk);
        check("lat_check_cycle_we", {63'b0, mem_we}, 64'd0);
        @(negedge clk);
        check("lat_write_cycle_we", {63'b0, mem_we}, 64'd1);
        check_state();
        check("beq_word", {32'b0, wlog_data[0]}, 64'hFE0006E3);
        check("beq_addr", {56'b0, wlog_addr[0]}, 64'd0);
        check("beq_next_addr", {56'b0, mem_addr}, 64'd1);

        // clear with addi, then sw back-to-back
        send(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd5, 5'd4, 5'd0, 50, 1'b1);
        send(3'd2, 7'b0100011, 3'd2, 7'd0, 5'd0, 5'd0, 5'd4, 18, 1'b0);
        send(3'd4, 7'b0010111, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 64'h1000, 1'b0);
        check_state();
        check("addi_word", {32'b0, wlog_data[1]}, 64'h03220293);
        check("addi_addr", {56'b0, wlog_addr[1]}, 64'd0);
        check("sw_word", {32'b0, wlog_data[2]}, 64'h00402923);
        check("sw_addr", {56'b0, wlog_addr[2]}, 64'd1);
        check("auipc_word", {32'b0, wlog_data[3]}, 64'h00001297);

        // rejected bundles
        err0 = err_pulses;
        send(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd5, 5'd4, 5'd0, 2048, 1'b0);
        send(3'd3, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 5, 1'b0);
        check_state();
        check("rej_pulses", 64'(err_pulses - err0), 64'd2);
        check("rej_err_count", {56'b0, err_count}, 64'd2);
        check("rej_addr", {56'b0, mem_addr}, 64'd3);

        // backpressure
        mem_ready = 1'b0;
        send(3'd0, 7'b0110011, 3'd7, 7'h20, 5'd9, 5'd10, 5'd11, 0, 1'b0);
        wait_we();
        held = mem_wdata;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_we", {63'b0, mem_we}, 64'd1);
            check("bp_data", {32'b0, mem_wdata}, {32'b0, held});
            check("bp_addr", {56'b0, mem_addr}, 64'd3);
        end
        mem_ready = 1'b1;
        check_state();

        // randomized traffic
        rand_ready = 1'b1;
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 4))
                0: v = longint'($urandom_range(0, 10000)) - 5000;
                1: v = bnd[$urandom_range(0, 15)];
                2: v = {$urandom, $urandom};
                3: v = longint'(int'($urandom & 32'hFFFFF000));
                default: v = longint'($urandom_range(0, 4194304)) - 2097152;
            endcase
            send(3'($urandom_range(0, 7)), 7'($urandom), 3'($urandom), 7'($urandom),
                 5'($urandom), 5'($urandom), 5'($urandom), v, ($urandom_range(0, 7) == 0));
            check_state();
        end

        // fill to 255 then wrap
        send(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd1, 5'd0, 1, 1'b1);
        for (int n = 1; n < 255; n++) begin
            send(3'd1, 7'b0010011, 3'd0, 7'd0, 5'($urandom), 5'd1, 5'd0,
                 longint'($urandom_range(0, 2047)), 1'b0);
        end
        check_state();
        check("pre_wrap_addr", {56'b0, mem_addr}, 64'd255);
        send(3'd5, 7'b1101111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 2048, 1'b0);
        check_state();
        check("wrap_write_addr", {56'b0, wlog_addr[wlog_addr.size() - 1]}, 64'd255);
        check("wrap_next_addr", {56'b0, mem_addr}, 64'd0);
        check("wrap_flag", {63'b0, wrapped}, 64'd1);

        // reset while a write is pending
        rand_ready = 1'b0;
        mem_ready = 1'b0;
        send(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd3, 5'd3, 5'd0, 7, 1'b0);
        wait_we();
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        exp_q.delete();
        m_addr = 0;
        m_err = 0;
        m_wrapped = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b1;
        send(3'd2, 7'b0100011, 3'd2, 7'd0, 5'd0, 5'd0, 5'd4, 18, 1'b0);
        check_state();
        check("post_rst_addr", {56'b0, wlog_addr[wlog_addr.size() - 1]}, 64'd0);
        check("post_rst_word", {32'b0, wlog_data[wlog_data.size() - 1]}, 64'h00402923);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
